fir_serial_mac: RTL and testbench
=================================

// Module: fir_serial_mac
// PURPOSE
//  Parametrised, runtime-programmable serial-MAC FIR filter; successor to the fixed 16-tap HPF.
//  Accepts samples as LSB-first chunks under valid/ready and keeps a TAPS-deep delay line.
//  Computes one output per sample with a single multiplier over TAPS cycles, then rounds and
//  saturates. Coefficients are writeable while idle, so one block serves HPF, LPF or any other FIR.
// PARAMETERS
//  DW    8   sample and output width; signed two's complement
//  NIB   4   input chunk width; DW % NIB must be 0; NCH = DW/NIB chunks per sample
//  TAPS  16  filter length (>=2); AW = $clog2(TAPS)
//  CW    16  coefficient width; signed two's complement
//  FRAC  12  coefficient fraction bits; result = acc >>> FRAC, rounded (FRAC>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        synchronous, active-high
//  x_in         in   NIB      sample chunk, LSB chunk first
//  x_in_valid   in   1        x_in valid this cycle
//  x_in_ready   out  1        block accepts a chunk (high only in IDLE)
//  coef_we      in   1        coefficient write strobe (honoured only in IDLE)
//  coef_addr    in   AW       tap index k; k=0 multiplies the newest sample
//  coef_data    in   CW       coefficient value h[k]
//  busy         out  1        high in MAC
//  z_valid      out  1        one-cycle pulse, z valid
//  z            out  DW       filtered sample, signed; held until the next result
// BEHAVIOUR
//  - Reset applies in any state. It clears x[0..TAPS-1], h[0..TAPS-1], the chunk counter,
//    the accumulator, the tap counter, z and z_valid, and forces state to IDLE.
//    After reset: x_in_ready=1, busy=0, z_valid=0, z=0.
//  - States: IDLE, MAC.
//  - IDLE: x_in_ready=1. On each edge with x_in_valid=1, chunk c (0..NCH-1) is stored into
//    bits [c*NIB +: NIB] of the assembly register and the counter increments.
//    A gap in x_in_valid stalls assembly; partial chunks are held, never dropped.
//  - Edge that accepts chunk NCH-1:
//      delay line shifts (x[k] <= x[k-1]); x[0] <= assembled sample (last chunk included);
//      acc <= 0, tap counter k <= 0, chunk counter <= 0, state -> MAC.
//  - MAC: x_in_ready=0 (x_in_valid ignored), busy=1. Each edge: acc <= acc + x[k]*h[k], k++.
//    Product is a full signed DW x CW. ACCW = DW+CW+AW, so the accumulator cannot overflow.
//  - Edge with k == TAPS-1: final sum s = acc + x[TAPS-1]*h[TAPS-1].
//      z <= sat_DW((s + 2^(FRAC-1)) >>> FRAC); z_valid <= 1; state -> IDLE.
//    Rounding is round-half-up (toward +inf).
//    sat_DW clamps to [-2^(DW-1), 2^(DW-1)-1].
//  - z_valid is high for exactly one cycle, then returns to 0.
//  - Latency: last chunk accepted at edge E gives z_valid high in the cycle after edge E+TAPS.
//  - Throughput: one sample per NCH+TAPS cycles when chunks arrive back-to-back.
//    IDLE accepts chunk 0 in the same cycle z_valid is high.
//  - Coefficient writes: coef_we in IDLE updates h[coef_addr] at the edge.
//    coef_we in MAC is ignored. h[] is never modified mid-computation.
//    A write on the same edge as the last chunk takes effect and is used by that MAC pass.
//  - coef_addr >= TAPS (non-power-of-2 TAPS): write is ignored.
//  - Delay line starts at zero; the first TAPS-1 outputs use zero history.
// TESTING (DW=8 NIB=4 TAPS=16 CW=16 FRAC=12)
//  1 Impulse: h[0]=0x1000, others 0; chunks 5,2 (x=0x25) -> one z_valid pulse 16 cycles
//    after the last chunk's edge, z=0x25. x_in_ready=0 for exactly 16 cycles.
//  2 Rounding: h[0]=0x0800; x=0x03 -> z=0x02; x=0xFD -> z=0xFF; x=0x01 -> z=0x01.
//  3 Saturation: h[0]=0x7FFF; x=0x7F -> z=0x7F; x=0x80 -> z=0x80; x=0x00 -> z=0x00.
//  4 Delay/taps: h[3]=0x1000, others 0; samples 1,2,3,4,5 -> z=0,0,0,1,2.
//    Then HPF set {FFF8,0010,0020,FFA0,FF40,0140,0280,F800,0800,FD80,FEC0,00C0,0060,FFE0,FFF0,0008}
//    driven by a random stream: z matches a golden model bit-exactly.
//  5 Handshake: random x_in_valid gaps between chunks -> same z as gap-free.
//    Chunks driven during MAC -> ignored. coef_we during MAC -> h unchanged (read back via test 1).
//  6 Reset mid-MAC at k=7 -> next cycle busy=0, z_valid=0, z=0, x_in_ready=1.
//    Reload h[0]=0x1000, feed x=0x11 -> z=0x11 with no residual history.

Source files
------------

// File: rtl/fir_serial_mac.sv
// Runtime-programmable FIR filter with one shared multiplier: samples arrive as LSB-first chunks,
// then TAPS multiply-accumulate cycles produce one rounded, saturated output per sample.
module fir_serial_mac #(
  parameter int DW   = 8,
  parameter int NIB  = 4,
  parameter int TAPS = 16,
  parameter int CW   = 16,
  parameter int FRAC = 12,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NIB-1:0]       x_in,
  input  logic                 x_in_valid,
  output logic                 x_in_ready,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic [CW-1:0]        coef_data,
  output logic                 busy,
  output logic                 z_valid,
  output logic signed [DW-1:0] z
);

  localparam int NCH  = DW / NIB;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;

  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC - 1);
  localparam logic signed [ACCW-1:0] ZMAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] ZMIN = -ZMAX - ACCW'(1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                  state;
  logic [CHW-1:0]          chunk_cnt;
  logic [DW-1:0]           asm_reg;
  logic [AW-1:0]           k;
  logic signed [ACCW-1:0]  acc;
  logic signed [DW-1:0]    x [TAPS];
  logic signed [CW-1:0]    h [TAPS];

  logic [DW-1:0]           sample_next;
  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    h_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_next;
  logic signed [ACCW-1:0]  shifted;
  logic signed [DW-1:0]    z_next;
  logic                    addr_ok;

  // Zero-extended compare so a non-power-of-2 TAPS rejects out-of-range tap addresses.
  assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  always_comb begin
    sample_next = asm_reg;
    sample_next[int'(chunk_cnt)*NIB +: NIB] = x_in;
    x_ext    = PW'(x[k]);
    h_ext    = PW'(h[k]);
    prod     = x_ext * h_ext;
    acc_next = acc + ACCW'(prod);
    shifted  = (acc_next + HALF) >>> FRAC;
    if (shifted > ZMAX)
      z_next = ZMAX[DW-1:0];
    else if (shifted < ZMIN)
      z_next = ZMIN[DW-1:0];
    else
      z_next = shifted[DW-1:0];
  end

  // Single FSM: IDLE assembles chunks and takes coefficient writes, MAC walks the taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_in_ready <= 1'b1;
      busy       <= 1'b0;
      z_valid    <= 1'b0;
      z          <= '0;
      chunk_cnt  <= '0;
      asm_reg    <= '0;
      k          <= '0;
      acc        <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      z_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we && addr_ok)
            h[coef_addr] <= coef_data;
          if (x_in_valid) begin
            asm_reg <= sample_next;
            if (chunk_cnt == CHW'(NCH - 1)) begin
              for (int i = TAPS - 1; i > 0; i--)
                x[i] <= x[i-1];
              x[0]       <= sample_next;
              acc        <= '0;
              k          <= '0;
              chunk_cnt  <= '0;
              state      <= MAC;
              x_in_ready <= 1'b0;
              busy       <= 1'b1;
            end else begin
              chunk_cnt <= chunk_cnt + CHW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + AW'(1);
          if (k == AW'(TAPS - 1)) begin
            z          <= z_next;
            z_valid    <= 1'b1;
            state      <= IDLE;
            x_in_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed and randomized checks of fir_serial_mac against an arithmetic FIR model.
module tb_fir_serial_mac;
  localparam int DW   = 8;
  localparam int NIB  = 4;
  localparam int TAPS = 16;
  localparam int CW   = 16;
  localparam int FRAC = 12;
  localparam int AW   = 4;
  localparam int NCH  = DW / NIB;

  logic          clk = 1'b0;
  logic          reset;
  logic [NIB-1:0] x_in;
  logic          x_in_valid;
  logic          x_in_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          busy;
  logic          z_valid;
  logic [DW-1:0] z;

  int vectors     = 0;
  int miscompares = 0;
  longint mx [TAPS];
  longint mh [TAPS];
  logic [DW-1:0] last_z;

  logic [15:0] hpf [TAPS] = '{16'hFFF8, 16'h0010, 16'h0020, 16'hFFA0, 16'hFF40, 16'h0140,
                              16'h0280, 16'hF800, 16'h0800, 16'hFD80, 16'hFEC0, 16'h00C0,
                              16'h0060, 16'hFFE0, 16'hFFF0, 16'h0008};

  fir_serial_mac #(.DW(DW), .NIB(NIB), .TAPS(TAPS), .CW(CW), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
    .z_valid(z_valid), .z(z)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: push sample into history, full-precision dot product, round half up, clamp.
  function automatic logic [DW-1:0] modelPush(input logic [DW-1:0] sample);
    longint s = 0;
    longint r;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = longint'($signed(sample));
    for (int i = 0; i < TAPS; i++) s += mx[i] * mh[i];
    r = (s + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[DW-1:0];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mh[i] = 0;
    end
  endtask

  task automatic writeCoef(input int addr, input logic [CW-1:0] data);
    coef_addr = addr[AW-1:0];
    coef_data = data;
    coef_we   = 1'b1;
    @(posedge clk); #1;
    coef_we   = 1'b0;
    mh[addr]  = longint'($signed(data));
  endtask

  task automatic loadOnly(input int addr, input logic [CW-1:0] data);
    for (int i = 0; i < TAPS; i++) writeCoef(i, (i == addr) ? data : 16'h0000);
  endtask

  // Sends one sample (optionally with valid gaps), optionally drives junk while MAC runs,
  // then waits for the result and checks value, latency and ready-low duration.
  task automatic applyStimulus(input logic [DW-1:0] sample, input bit gaps, input bit noise);
    logic [DW-1:0] exp_z;
    int cycles = 0;
    int ready_low = 0;
    for (int c = 0; c < NCH; c++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          x_in = 4'($urandom);
          @(posedge clk); #1;
        end
      end
      x_in       = sample[c*NIB +: NIB];
      x_in_valid = 1'b1;
      @(posedge clk); #1;
      x_in_valid = 1'b0;
    end
    exp_z = modelPush(sample);
    if (noise) begin
      x_in       = 4'($urandom);
      x_in_valid = 1'b1;
      coef_we    = 1'b1;
      coef_addr  = 4'($urandom);
      coef_data  = 16'($urandom);
    end
    while (!z_valid && cycles < 40) begin
      if (!x_in_ready) ready_low++;
      @(posedge clk); #1;
      cycles++;
    end
    x_in_valid = 1'b0;
    coef_we    = 1'b0;
    checkOutput("z_valid_seen", 32'(z_valid), 32'd1);
    checkOutput("latency", cycles, TAPS);
    checkOutput("ready_low_cycles", ready_low, TAPS);
    checkOutput("z_vs_model", 32'(z), 32'(exp_z));
    last_z = z;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelClear();
  endtask

  initial begin
    reset = 1'b1; x_in = '0; x_in_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    modelClear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_ready", 32'(x_in_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_zvalid", 32'(z_valid), 32'd0);
    checkOutput("reset_z", 32'(z), 32'd0);

    $display("[TB] impulse");
    writeCoef(0, 16'h1000);
    applyStimulus(8'h25, 1'b0, 1'b0);
    checkOutput("impulse_z", 32'(last_z), 32'h25);
    @(posedge clk); #1;
    checkOutput("zvalid_one_cycle", 32'(z_valid), 32'd0);
    checkOutput("z_held", 32'(z), 32'h25);

    $display("[TB] rounding");
    writeCoef(0, 16'h0800);
    applyStimulus(8'h03, 1'b0, 1'b0); checkOutput("round_03", 32'(last_z), 32'h02);
    applyStimulus(8'hFD, 1'b0, 1'b0); checkOutput("round_FD", 32'(last_z), 32'hFF);
    applyStimulus(8'h01, 1'b0, 1'b0); checkOutput("round_01", 32'(last_z), 32'h01);

    $display("[TB] saturation");
    writeCoef(0, 16'h7FFF);
    applyStimulus(8'h7F, 1'b0, 1'b0); checkOutput("sat_7F", 32'(last_z), 32'h7F);
    applyStimulus(8'h80, 1'b0, 1'b0); checkOutput("sat_80", 32'(last_z), 32'h80);
    applyStimulus(8'h00, 1'b0, 1'b0); checkOutput("sat_00", 32'(last_z), 32'h00);

    $display("[TB] delay taps");
    doReset();
    writeCoef(3, 16'h1000);
    applyStimulus(8'd1, 1'b0, 1'b0); checkOutput("tap3_s1", 32'(last_z), 32'd0);
    applyStimulus(8'd2, 1'b0, 1'b0); checkOutput("tap3_s2", 32'(last_z), 32'd0);
    applyStimulus(8'd3, 1'b0, 1'b0); checkOutput("tap3_s3", 32'(last_z), 32'd0);
    applyStimulus(8'd4, 1'b0, 1'b0); checkOutput("tap3_s4", 32'(last_z), 32'd1);
    applyStimulus(8'd5, 1'b0, 1'b0); checkOutput("tap3_s5", 32'(last_z), 32'd2);

    $display("[TB] hpf random stream");
    for (int i = 0; i < TAPS; i++) writeCoef(i, hpf[i]);
    for (int n = 0; n < 40; n++)
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom));

    $display("[TB] coefficients untouched by MAC-time writes");
    loadOnly(0, 16'h1000);
    applyStimulus(8'h5A, 1'b1, 1'b1);
    applyStimulus(8'h25, 1'b0, 1'b1);
    checkOutput("impulse_after_noise", 32'(last_z), 32'h25);

    $display("[TB] reset mid-MAC");
    for (int i = 0; i < TAPS; i++) writeCoef(i, hpf[i]);
    for (int c = 0; c < NCH; c++) begin
      x_in = 8'h6B >> (c * NIB);
      x_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    x_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    doReset();
    checkOutput("midmac_busy", 32'(busy), 32'd0);
    checkOutput("midmac_zvalid", 32'(z_valid), 32'd0);
    checkOutput("midmac_z", 32'(z), 32'd0);
    checkOutput("midmac_ready", 32'(x_in_ready), 32'd1);
    writeCoef(0, 16'h1000);
    applyStimulus(8'h11, 1'b0, 1'b0);
    checkOutput("post_reset_z", 32'(last_z), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
